vram_fill: RTL



---
 rtl/vram_fill.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vram_fill.sv
// Rectangle-fill engine driving the VRAM write port: one pixel write per cycle, row-major.
// Latency: first write one cycle after command acceptance; done one cycle after the last write.
// Backpressure: vram_busy stalls the walk cycle-by-cycle; cmd_ready is high only while idle.
//
// Ports:
//   clk_53_2MHz, rst           - system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        - fill command handshake (accepted on valid & ready)
//   cmd_x/cmd_y/cmd_w/cmd_h    - rectangle origin (column, line) and size (pixels, lines)
//   cmd_mode/cmd_color         - pixel mode code and 24-bit fill word
//   vram_busy                  - VRAM port owned by another master this cycle
//   vram_*                     - VRAM port: address, mode, write strobe, data, drive enable
//   done                       - one-cycle pulse after the last write of a command
module vram_fill (
    input  logic        clk_53_2MHz,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [12:0] cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [3:0]  cmd_mode,
    input  logic [23:0] cmd_color,
    input  logic        vram_busy,
    output logic [8:0]  vram_line,
    output logic [11:0] vram_col,
    output logic [3:0]  vram_mode,
    output logic        vram_we,
    output logic        vram_re,
    output logic [23:0] vram_data_out,
    output logic        vram_data_oe,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched command and walk counters
    logic [11:0] x_q;
    logic [11:0] col_cnt;
    logic [11:0] end_col;
    logic [8:0]  line_cnt;
    logic [8:0]  end_line;
    logic [3:0]  mode_q;
    logic [23:0] color_q;

    // Clipping of the incoming command against the 4096 x 512 surface
    logic [12:0] w_room;
    logic [12:0] w_eff;
    logic [9:0]  h_room;
    logic [9:0]  h_eff;
    logic [11:0] end_col_nxt;
    logic [8:0]  end_line_nxt;
    logic        empty_rect;

    logic accept;
    logic wr;
    logic last_col;
    logic last_wr;

    always_comb begin
        w_room = 13'd4096 - {1'b0, cmd_x};
        h_room = 10'd512 - {1'b0, cmd_y};
        w_eff  = (cmd_w < w_room) ? cmd_w : w_room;
        h_eff  = (cmd_h < h_room) ? cmd_h : h_room;
        // Modulo-4096 arithmetic: a full-width rectangle (w_eff=4096, x=0)
        // has w_eff[11:0]=0 and correctly yields end column 4095.
        end_col_nxt  = cmd_x + w_eff[11:0] - 12'd1;
        end_line_nxt = cmd_y + h_eff[8:0] - 9'd1;
        empty_rect   = (w_eff == 13'd0) || (h_eff == 10'd0);
    end

    assign accept   = (state == IDLE) && cmd_valid;
    assign wr       = (state == FILL) && !vram_busy;
    assign last_col = (col_cnt == end_col);
    assign last_wr  = wr && last_col && (line_cnt == end_line);

    always_ff @(posedge clk_53_2MHz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        done          = 1'b0;
        vram_we       = 1'b0;
        vram_data_oe  = 1'b0;
        vram_re       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = empty_rect ? DONE : FILL;
                end
            end
            FILL: begin
                vram_we      = wr;
                vram_data_oe = wr;
                if (last_wr) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_53_2MHz or posedge rst) begin
        if (rst) begin
            x_q      <= 12'd0;
            col_cnt  <= 12'd0;
            end_col  <= 12'd0;
            line_cnt <= 9'd0;
            end_line <= 9'd0;
            mode_q   <= 4'd0;
            color_q  <= 24'd0;
        end else if (accept) begin
            x_q      <= cmd_x;
            col_cnt  <= cmd_x;
            line_cnt <= cmd_y;
            end_col  <= end_col_nxt;
            end_line <= end_line_nxt;
            mode_q   <= cmd_mode;
            color_q  <= cmd_color;
        end else if (wr) begin
            if (last_col) begin
                col_cnt <= x_q;
                // Hold the line on the final write so a fill ending on
                // line 511 never rolls the address over to line 0.
                if (!last_wr) begin
                    line_cnt <= line_cnt + 9'd1;
                end
            end else begin
                col_cnt <= col_cnt + 12'd1;
            end
        end
    end

    assign vram_line     = line_cnt;
    assign vram_col      = col_cnt;
    assign vram_mode     = mode_q;
    assign vram_data_out = color_q;

endmodule
